// File: rtl/irrigation_zone_scheduler_if.sv
// Sensor, field-input and driver/status bundle for irrigation_zone_scheduler.
// The master side (sensors/field) drives the inputs and the slave side
// (scheduler) drives the valves and the status outputs.
interface irrigation_zone_scheduler_if #(
  parameter int ZONES = 4
);
  localparam int ZW = $clog2(ZONES);

  // raw tank sensors, field inputs and operator request
  logic             low_water_level;
  logic             mid_water_level;
  logic             high_water_level;
  logic [ZONES-1:0] earth_humidity;
  logic             air_humidity;
  logic             low_temperature;
  logic             fault_clear;

  // valve/pump drivers and status
  logic             water_supply_valvule;
  logic [ZONES-1:0] zone_valvule;
  logic             splinker_bomb;
  logic             dripper_valvule;
  logic [ZW-1:0]    active_zone;
  logic             irrigation_active;
  logic             alarm;
  logic             fault;
  logic [1:0]       water_level_code;

  modport master (
    output low_water_level, mid_water_level, high_water_level, earth_humidity,
           air_humidity, low_temperature, fault_clear,
    input  water_supply_valvule, zone_valvule, splinker_bomb, dripper_valvule,
           active_zone, irrigation_active, alarm, fault, water_level_code
  );

  modport slave (
    input  low_water_level, mid_water_level, high_water_level, earth_humidity,
           air_humidity, low_temperature, fault_clear,
    output water_supply_valvule, zone_valvule, splinker_bomb, dripper_valvule,
           active_zone, irrigation_active, alarm, fault, water_level_code
  );
endinterface

// File: rtl/irrigation_zone_scheduler.sv
// Round-robin irrigation scheduler: debounced tank levels, sticky fault latch,
// hysteretic fill valve with timeout, and an IDLE/RUN/SETTLE zone sequencer.
module irrigation_zone_scheduler #(
  parameter int ZONES               = 4,
  parameter int DEBOUNCE_CYCLES     = 4,
  parameter int MAX_RUN_CYCLES      = 16,
  parameter int SETTLE_CYCLES       = 2,
  parameter int FILL_TIMEOUT_CYCLES = 64
) (
  input  logic                          clock,
  input  logic                          reset_n,
  irrigation_zone_scheduler_if.slave    bus
);
  localparam int ZW  = $clog2(ZONES);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RCW = $clog2(MAX_RUN_CYCLES + 1);
  localparam int SCW = $clog2(SETTLE_CYCLES + 1);
  localparam int FCW = $clog2(FILL_TIMEOUT_CYCLES + 1);
  localparam logic [ZONES-1:0] ONE_HOT0 = 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SETTLE} state_t;

  // debounced levels, bit 0 = low, 1 = mid, 2 = high
  logic [2:0]           w_raw;
  logic [2:0]           r_db;
  logic [2:0][DBW-1:0]  r_db_cnt;

  logic                 r_fault;
  logic                 r_valve;
  logic [FCW-1:0]       r_fill_cnt;

  state_t               r_state;
  logic [ZW-1:0]        r_active_zone;
  logic [ZW-1:0]        r_last_zone;
  logic                 r_spr;
  logic [RCW-1:0]       r_run_cnt;
  logic [SCW-1:0]       r_settle_cnt;

  logic                 w_conflict;
  logic                 w_fill_to;
  logic                 w_prereq;
  logic [ZONES-1:0]     w_elig;
  logic                 w_found;
  logic [ZW-1:0]        w_sel;
  logic [1:0]           w_code;

  assign w_raw      = {bus.high_water_level, bus.mid_water_level, bus.low_water_level};
  assign w_conflict = (r_db[2] & ~r_db[1]) | (r_db[1] & ~r_db[0]);
  // this edge closes the FILL_TIMEOUT_CYCLES-th consecutive open cycle
  assign w_fill_to  = r_valve & (r_fill_cnt == FCW'(FILL_TIMEOUT_CYCLES - 1));
  assign w_prereq   = r_db[0] & ~r_fault;
  assign w_elig     = ~bus.earth_humidity;

  // per-sensor debounce: take the raw value after DEBOUNCE_CYCLES disagreeing edges
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_db     <= '0;
      r_db_cnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_raw[i] != r_db[i]) begin
          if (r_db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
            r_db[i]     <= w_raw[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  // sticky fault (set beats clear), hysteretic fill valve and its open-time counter
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_fault    <= 1'b0;
      r_valve    <= 1'b0;
      r_fill_cnt <= '0;
    end else begin
      if (w_conflict | w_fill_to)
        r_fault <= 1'b1;
      else if (bus.fault_clear)
        r_fault <= 1'b0;

      if (r_fault | r_db[2])
        r_valve <= 1'b0;
      else if (!r_db[1])
        r_valve <= 1'b1;

      r_fill_cnt <= r_valve ? r_fill_cnt + 1'b1 : '0;
    end
  end

  // next zone: first eligible one after last_zone, wrapping, so last_zone comes last
  always_comb begin
    int            idx;
    logic [ZW-1:0] cand;
    idx     = 0;
    cand    = '0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 1; k <= ZONES; k++) begin
      idx = int'(r_last_zone) + k;
      if (idx >= ZONES) idx = idx - ZONES;
      cand = ZW'(idx);
      if (!w_found && w_elig[cand]) begin
        w_found = 1'b1;
        w_sel   = cand;
      end
    end
  end

  // zone sequencer: pick and latch zone/mode, run bounded time, then dead time
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_active_zone <= '0;
      r_last_zone   <= ZW'(ZONES - 1);
      r_spr         <= 1'b0;
      r_run_cnt     <= '0;
      r_settle_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_prereq && w_found) begin
            r_active_zone <= w_sel;
            r_last_zone   <= w_sel;
            r_spr         <= ~bus.air_humidity & ~bus.low_temperature & r_db[1];
            r_run_cnt     <= '0;
            r_state       <= S_RUN;
          end
        end
        S_RUN: begin
          r_run_cnt <= r_run_cnt + 1'b1;
          if (bus.earth_humidity[r_active_zone] || !w_prereq ||
              r_run_cnt == RCW'(MAX_RUN_CYCLES - 1)) begin
            r_settle_cnt <= '0;
            r_state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == SCW'(SETTLE_CYCLES - 1))
            r_state <= S_IDLE;
          else
            r_settle_cnt <= r_settle_cnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // level code from debounced bits; a conflicting pattern reads as empty
  always_comb begin
    w_code = 2'd0;
    if (!w_conflict) begin
      if (r_db[2])      w_code = 2'd3;
      else if (r_db[1]) w_code = 2'd2;
      else if (r_db[0]) w_code = 2'd1;
    end
  end

  assign bus.water_supply_valvule = r_valve;
  assign bus.zone_valvule         = (r_state == S_RUN) ? (ONE_HOT0 << r_active_zone) : '0;
  assign bus.splinker_bomb        = (r_state == S_RUN) & r_spr;
  assign bus.dripper_valvule      = (r_state == S_RUN) & ~r_spr;
  assign bus.active_zone          = r_active_zone;
  assign bus.irrigation_active    = (r_state == S_RUN);
  assign bus.fault                = r_fault;
  assign bus.water_level_code     = w_code;
  // held low while reset is asserted so every output reads 0 in reset
  assign bus.alarm                = reset_n & (r_fault | ~r_db[0]);
endmodule
